m65_phi_slot_arbiter: RTL and testbench

M65_PHI_SLOT_ARBITER -- requirements
Module: m65_phi_slot_arbiter

---
 rtl/m65_arb_pkg.sv | 17 +
 rtl/m65_phi_slot_arbiter.sv | 83 ++++++++
 tb/tb_m65_phi_slot_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/m65_arb_pkg.sv
// m65_arb_pkg: shared state/owner encodings and the default watchdog limit
package m65_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_CYC = 2'd1,
        DMA_CYC = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/m65_phi_slot_arbiter.sv
// m65_phi_slot_arbiter: phi-paced CPU/DMA bus slot arbiter with round-robin and RMW lock.
// Define M65_ARB_TIMEOUT_EN to build in the bus_ready watchdog.
module m65_phi_slot_arbiter
    import m65_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic phi_tick,
    input  logic fast_mode,
    input  logic cpu_req,
    input  logic cpu_lock,
    input  logic dma_req,
    input  logic bus_ready,
    output logic cpu_gnt,
    output logic dma_gnt,
    output logic bus_strobe,
    output logic slot_overrun,
    output logic timeout_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    arb_state_t state, state_n;
    owner_t     last_owner;
    logic       slot_pending;
    logic       grant_start;
    logic       cpu_pick;
    logic       wd_hit;

    always_comb begin
        grant_start = (state == IDLE) && slot_pending && (cpu_req || dma_req);
        // lock only extends an existing CPU ownership; otherwise plain round-robin
        cpu_pick    = cpu_req && (!dma_req || last_owner == OWN_DMA || cpu_lock);
        state_n     = state;
        if (state == IDLE)
            state_n = grant_start ? (cpu_pick ? CPU_CYC : DMA_CYC) : IDLE;
        else if (bus_ready || wd_hit)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_owner   <= OWN_DMA;
            slot_pending <= 1'b0;
            bus_strobe   <= 1'b0;
            slot_overrun <= 1'b0;
        end else begin
            state        <= state_n;
            bus_strobe   <= grant_start;
            if (grant_start)
                last_owner <= cpu_pick ? OWN_CPU : OWN_DMA;
            // a new slot arriving on the grant edge survives the consume
            slot_pending <= fast_mode || phi_tick || (slot_pending && !grant_start);
            if (phi_tick && !fast_mode && slot_pending)
                slot_overrun <= 1'b1;
        end
    end

`ifdef M65_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || grant_start)
            wd_cnt <= 8'd0;
        else if (state != IDLE && !bus_ready && !wd_hit)
            wd_cnt <= wd_cnt + 8'd1;
    end

    assign wd_hit = (state != IDLE) && (wd_cnt == 8'(TIMEOUT_CYCLES));
`else
    assign wd_hit = 1'b0;
`endif

    assign cpu_gnt     = (state == CPU_CYC);
    assign dma_gnt     = (state == DMA_CYC);
    assign timeout_err = wd_hit;

endmodule

// File: tb/tb_m65_phi_slot_arbiter.sv
// tb_m65_phi_slot_arbiter: directed vectors with hand-computed expectations for the slot arbiter.
module tb_m65_phi_slot_arbiter;

    logic clk = 1'b0;
    logic reset, phi_tick, fast_mode, cpu_req, cpu_lock, dma_req, bus_ready;
    logic cpu_gnt, dma_gnt, bus_strobe, slot_overrun, timeout_err;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    m65_phi_slot_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .phi_tick(phi_tick), .fast_mode(fast_mode),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .dma_req(dma_req), .bus_ready(bus_ready),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .bus_strobe(bus_strobe),
        .slot_overrun(slot_overrun), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {phi_tick, fast_mode, cpu_req, cpu_lock, dma_req, bus_ready} = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] pat [8];
        logic       held;
        int         grants;
        pat = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        @(negedge clk);

        // reset state and single-requester grant
        do_reset();
        chk("rst_outs", {3'b0, cpu_gnt, dma_gnt, bus_strobe, slot_overrun, timeout_err}, 8'h00);
        cpu_req = 1'b1;
        repeat (3) step();
        chk("no_slot_no_gnt", cpu_gnt, 0);
        phi_tick = 1'b1;
        step();
        phi_tick = 1'b0;
        chk("pending_cycle", cpu_gnt, 0);
        step();
        chk("cpu_gnt_start", {cpu_gnt, dma_gnt, bus_strobe}, 3'b101);
        cpu_req = 1'b0;
        step();
        chk("cpu_hold_no_req", {cpu_gnt, bus_strobe}, 2'b10);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("cpu_drop", {cpu_gnt, dma_gnt}, 2'b00);

        // fast mode alternation with one idle cycle between grants
        do_reset();
        {fast_mode, cpu_req, dma_req, bus_ready} = 4'hf;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("fast_%0d", i), {cpu_gnt, dma_gnt}, pat[i]);
            chk($sformatf("fast_stb_%0d", i), bus_strobe, pat[i] != 2'b00);
        end

        // lock keeps CPU, unlocked falls back to round-robin
        do_reset();
        {cpu_req, dma_req, cpu_lock, bus_ready, phi_tick} = 5'h1f;
        step();
        phi_tick = 1'b0;
        step();
        chk("lock_first_cpu", {cpu_gnt, dma_gnt}, 2'b10);
        phi_tick = 1'b1;
        step();
        phi_tick = 1'b0;
        chk("lock_idle", {cpu_gnt, dma_gnt}, 2'b00);
        step();
        chk("lock_cpu_again", {cpu_gnt, dma_gnt}, 2'b10);
        cpu_lock = 1'b0;
        phi_tick = 1'b1;
        step();
        phi_tick = 1'b0;
        step();
        chk("unlock_dma", {cpu_gnt, dma_gnt}, 2'b01);

        // overrun is sticky and a waiting slot gives exactly one grant
        do_reset();
        phi_tick = 1'b1;
        step();
        chk("ovr_first_tick", slot_overrun, 0);
        phi_tick = 1'b0;
        step();
        phi_tick = 1'b1;
        step();
        phi_tick = 1'b0;
        chk("ovr_set", slot_overrun, 1);
        {cpu_req, bus_ready} = 2'b11;
        step();
        chk("ovr_grant", {cpu_gnt, bus_strobe}, 2'b11);
        grants = 0;
        repeat (6) begin
            step();
            grants += int'(bus_strobe);
        end
        chk("ovr_one_grant", 8'(grants), 0);
        chk("ovr_sticky", slot_overrun, 1);

        // watchdog
        do_reset();
        chk("rst_clears_ovr", slot_overrun, 0);
        {dma_req, phi_tick} = 2'b11;
        step();
        phi_tick = 1'b0;
        step();
        chk("wd_dma_start", {dma_gnt, bus_strobe, timeout_err}, 3'b110);
`ifdef M65_ARB_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("wd_cyc_%0d", i), {dma_gnt, timeout_err}, {1'b1, i == 4});
        end
        step();
        chk("wd_abort_idle", {dma_gnt, timeout_err}, 2'b00);
`else
        held = 1'b1;
        repeat (100) begin
            step();
            held &= dma_gnt & ~timeout_err;
        end
        chk("wd_hold_100", held, 1);
        bus_ready = 1'b1;
        step();
        chk("wd_ready_drop", {dma_gnt, timeout_err}, 2'b00);
`endif

        // reset mid DMA cycle
        do_reset();
        {dma_req, phi_tick} = 2'b11;
        step();
        phi_tick = 1'b0;
        step();
        chk("rst_dma_gnt", dma_gnt, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_cyc", {cpu_gnt, dma_gnt, bus_strobe}, 3'b000);
        {cpu_req, bus_ready, phi_tick} = 3'b111;
        step();
        phi_tick = 1'b0;
        step();
        chk("rst_then_cpu", {cpu_gnt, dma_gnt}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    always @(negedge clk)
        if (cpu_gnt && dma_gnt) begin
            vectors++;
            miscompares++;
            $display("FAIL gnt_exclusive: got cpu=%b dma=%b expected not both", cpu_gnt, dma_gnt);
        end

endmodule
